// File: rtl/uart_tx_frame.sv
// Configurable UART transmitter (5-9 data bits, none/odd/even parity, 1-2 stop bits) with input buffering.
// Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry input FIFO; otherwise a single holding register is used.
module uart_tx_frame #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_BITS-1:0]          s_data,
    input  logic                          s_valid,
    output logic                          s_ready,
    output logic                          tx,
    output logic                          busy,
    output logic                          done,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int                 BAUD_DIV  = CLK_FREQ / BAUD_RATE;
    localparam int                 BAUD_W    = $clog2(BAUD_DIV);
    localparam logic [BAUD_W-1:0]  BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [3:0]         DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]         STOP_LAST = 4'(STOP_BITS - 1);
    localparam int                 LVL_W     = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t                state_q, state_d;
    logic [BAUD_W-1:0]     baud_cnt_q, baud_cnt_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d;
    logic                  par_q, par_d;
    logic                  armed_q, armed_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  push, bypass, buf_push, pop, buf_empty;
    logic [DATA_BITS-1:0]  buf_head;

    function automatic logic parity_of(input logic [DATA_BITS-1:0] w);
        return (PARITY == 1) ? ~(^w) : (^w);
    endfunction

    // A word arriving at an idle transmitter with nothing queued is the next frame, not a buffered word.
    assign push     = s_valid && s_ready;
    assign bypass   = push && (state_q == S_IDLE) && !armed_q && buf_empty;
    assign buf_push = push && !bypass;

`ifdef UART_TX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]     count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(buf_push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + LVL_W'(buf_push) - LVL_W'(pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; flushing the pointers and count is enough to empty it.
    always_ff @(posedge clk) begin
        if (buf_push) mem_q[wr_ptr_q] <= s_data;
    end

    assign buf_empty = (count_q == '0);
    assign buf_head  = mem_q[rd_ptr_q];
    assign s_ready   = (count_q != LVL_W'(FIFO_DEPTH));
    assign level     = count_q;
`else
    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic                 hold_valid_q, hold_valid_d;

    always_comb begin
        hold_d       = buf_push ? s_data : hold_q;
        hold_valid_d = hold_valid_q;
        if (buf_push)  hold_valid_d = 1'b1;
        else if (pop)  hold_valid_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
        end
    end

    assign buf_empty = !hold_valid_q;
    assign buf_head  = hold_q;
    assign s_ready   = !hold_valid_q;
    assign level     = {{(LVL_W-1){1'b0}}, hold_valid_q};
`endif

    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = (state_q == S_IDLE || baud_cnt_q == BAUD_LAST) ? '0 : baud_cnt_q + BAUD_W'(1);
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        armed_d    = armed_q;
        pop        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (armed_q) begin
                    armed_d = 1'b0;
                    state_d = S_START;
                end else if (bypass) begin
                    shift_d = s_data;
                    par_d   = parity_of(s_data);
                    armed_d = 1'b1;
                end else if (!buf_empty) begin
                    pop     = 1'b1;
                    shift_d = buf_head;
                    par_d   = parity_of(buf_head);
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_cnt_q == BAUD_LAST) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                end
            end
            S_DATA: begin
                if (baud_cnt_q == BAUD_LAST) begin
                    if (bit_cnt_q == DATA_LAST) begin
                        state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
                        bit_cnt_d = '0;
                    end else begin
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (baud_cnt_q == BAUD_LAST) begin
                    state_d   = S_STOP;
                    bit_cnt_d = '0;
                end
            end
            S_STOP: begin
                if (baud_cnt_q == BAUD_LAST) begin
                    if (bit_cnt_q == STOP_LAST) begin
                        if (!buf_empty) begin
                            pop     = 1'b1;
                            shift_d = buf_head;
                            par_d   = parity_of(buf_head);
                            state_d = S_START;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered decodes of the next state so tx/busy/done line up with the bit they describe.
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
            S_PARITY: tx_d = par_d;
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_STOP) && (baud_cnt_d == BAUD_LAST) && (bit_cnt_d == STOP_LAST);
    end

    // NOTE: sequential state uses non-blocking assignments only; all next-state logic lives above.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            armed_q    <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            armed_q    <= armed_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: three instances (8N1, 7E2, 9O1), all with a 10-cycle bit period.
`timescale 1ns/1ps
module tb_uart_tx_frame;

`ifdef UART_TX_FIFO_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1;
`endif
    localparam int DIV = 10;

    typedef struct packed {
        logic [11:0] bits;   // line order: bit i is the i-th bit period on tx
        logic        b2b;    // frame must start the cycle after the previous one ends
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  sd0 = '0;
    logic [6:0]  sd1 = '0;
    logic [8:0]  sd2 = '0;
    logic [2:0]  sv = '0;
    wire  [2:0]  rdy_w, tx_w, busy_w, done_w;
    wire  [2:0]  lvl0, lvl1, lvl2;

    int   checks = 0;
    int   errors = 0;
    int   gcycle = 0;

    exp_t sb0[$], sb1[$], sb2[$];
    logic active [3];
    int   cyc [3], done_at [3], busy_bad [3], last_end [3];
    exp_t cur [3];

    always #5 clk = ~clk;
    always @(posedge clk) gcycle <= gcycle + 1;

    uart_tx_frame #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY(0),
                    .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
        .clk(clk), .reset(reset), .s_data(sd0), .s_valid(sv[0]), .s_ready(rdy_w[0]),
        .tx(tx_w[0]), .busy(busy_w[0]), .done(done_w[0]), .level(lvl0));

    uart_tx_frame #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(7), .PARITY(2),
                    .STOP_BITS(2), .FIFO_DEPTH(4)) u_7e2 (
        .clk(clk), .reset(reset), .s_data(sd1), .s_valid(sv[1]), .s_ready(rdy_w[1]),
        .tx(tx_w[1]), .busy(busy_w[1]), .done(done_w[1]), .level(lvl1));

    uart_tx_frame #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(9), .PARITY(1),
                    .STOP_BITS(1), .FIFO_DEPTH(4)) u_9o1 (
        .clk(clk), .reset(reset), .s_data(sd2), .s_valid(sv[2]), .s_ready(rdy_w[2]),
        .tx(tx_w[2]), .busy(busy_w[2]), .done(done_w[2]), .level(lvl2));

    task automatic check(input string name, input int ch, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s ch%0d: got %0d expected %0d (t=%0t)", name, ch, got, exp, $time);
        end
    endtask

    function automatic int nbits(input int c);
        return (c == 0) ? 10 : (c == 1) ? 11 : 12;
    endfunction

    function automatic int lvl(input int c);
        return (c == 0) ? int'(lvl0) : (c == 1) ? int'(lvl1) : int'(lvl2);
    endfunction

    function automatic int sb_size(input int c);
        return (c == 0) ? sb0.size() : (c == 1) ? sb1.size() : sb2.size();
    endfunction

    // Monitor: pops the expected frame when a start bit appears and checks it bit by bit.
    task automatic monitor_step(input int c);
        logic t, d, b, got_one;
        exp_t e;
        int   nb;
        t  = tx_w[c];
        d  = done_w[c];
        b  = busy_w[c];
        nb = nbits(c);
        if (!active[c]) begin
            if (t == 1'b0) begin
                got_one = 1'b1;
                e = '0;
                case (c)
                    0: if (sb0.size() > 0) e = sb0.pop_front(); else got_one = 1'b0;
                    1: if (sb1.size() > 0) e = sb1.pop_front(); else got_one = 1'b0;
                    default: if (sb2.size() > 0) e = sb2.pop_front(); else got_one = 1'b0;
                endcase
                if (!got_one) begin
                    check("unexpected_start", c, 1, 0);
                end else begin
                    cur[c]      = e;
                    active[c]   = 1'b1;
                    cyc[c]      = 0;
                    done_at[c]  = -1;
                    busy_bad[c] = 0;
                    if (e.b2b) check("no_idle_gap", c, gcycle, last_end[c] + 1);
                end
            end else if (d) begin
                check("spurious_done", c, 1, 0);
            end
        end
        if (active[c]) begin
            if (cyc[c] % DIV == DIV / 2)
                check("frame_bit", c, int'(t), int'(cur[c].bits[cyc[c] / DIV]));
            if (d) done_at[c] = (done_at[c] == -1) ? cyc[c] : -2;
            if (!b) busy_bad[c]++;
            if (cyc[c] == nb * DIV - 1) begin
                check("done_cycle", c, done_at[c], nb * DIV - 1);
                check("busy_held", c, busy_bad[c], 0);
                active[c]   = 1'b0;
                last_end[c] = gcycle;
            end
            cyc[c]++;
        end
    endtask

    always @(negedge clk) begin
        for (int c = 0; c < 3; c++) begin
            if (reset) active[c] = 1'b0;
            else       monitor_step(c);
        end
    end

    // Offer a word (called at a negedge); returns at the negedge after the accepting edge.
    task automatic send(input int c, input logic [8:0] d, input logic [11:0] fr,
                        input logic b2b, output int acc);
        int   t;
        exp_t e;
        t = 0;
        case (c)
            0: sd0 = d[7:0];
            1: sd1 = d[6:0];
            default: sd2 = d;
        endcase
        sv[c] = 1'b1;
        while (!rdy_w[c] && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (!rdy_w[c]) begin
            check("accept_timeout", c, 0, 1);
            sv[c] = 1'b0;
            acc = -1;
        end else begin
            e.bits = fr;
            e.b2b  = b2b;
            case (c)
                0: sb0.push_back(e);
                1: sb1.push_back(e);
                default: sb2.push_back(e);
            endcase
            @(posedge clk);
            #1 acc = gcycle;
            @(negedge clk);
            sv[c] = 1'b0;
        end
    endtask

    task automatic wait_idle(input int c);
        int t;
        t = 0;
        while ((busy_w[c] || active[c] || sb_size(c) != 0 || lvl(c) != 0) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("idle_reached", c, int'(t < 5000), 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc1, acc_x, k;
        for (int c = 0; c < 3; c++) begin
            active[c]   = 1'b0;
            cyc[c]      = 0;
            done_at[c]  = -1;
            busy_bad[c] = 0;
            last_end[c] = 0;
            cur[c]      = '0;
        end

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_tx", 0, int'(tx_w[0]), 1);
        check("rst_ready", 0, int'(rdy_w[0]), 1);
        check("rst_busy", 0, int'(busy_w[0]), 0);
        check("rst_done", 0, int'(done_w[0]), 0);
        check("rst_level", 0, lvl(0), 0);
        check("rst_tx", 1, int'(tx_w[1]), 1);
        check("rst_tx", 2, int'(tx_w[2]), 1);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 8N1 0xA5 with first-word latency
        send(0, 9'h0A5, {1'b1, 8'hA5, 1'b0}, 1'b0, acc1);
        check("lat_tx_before", 0, int'(tx_w[0]), 1);
        check("lat_busy_before", 0, int'(busy_w[0]), 0);
        check("lat_level_before", 0, lvl(0), 0);
        @(negedge clk);
        check("lat_tx_start", 0, int'(tx_w[0]), 0);
        check("lat_busy_start", 0, int'(busy_w[0]), 1);
        check("lat_level_start", 0, lvl(0), 0);
        wait_idle(0);

        // 7E2 0x53: data 1100101, even parity 0, two stop bits
        send(1, 9'h053, {2'b11, 1'b0, 7'h53, 1'b0}, 1'b0, acc1);
        wait_idle(1);

        // 9O1: 0x1FF -> parity 0, then 0x000 -> parity 1, back to back
        send(2, 9'h1FF, {1'b1, 1'b0, 9'h1FF, 1'b0}, 1'b0, acc1);
        send(2, 9'h000, {1'b1, 1'b1, 9'h000, 1'b0}, 1'b1, acc_x);
        wait_idle(2);

        // Fill the buffer while the line is busy, then keep offering
        send(0, 9'h001, {1'b1, 8'h01, 1'b0}, 1'b0, acc1);
        for (int i = 0; i < CAP; i++) begin
            logic [7:0] w;
            w = 8'(i + 2);
            send(0, {1'b0, w}, {1'b1, w, 1'b0}, 1'b1, acc_x);
        end
        check("full_level", 0, lvl(0), CAP);
        check("full_ready", 0, int'(rdy_w[0]), 0);
        check("full_busy", 0, int'(busy_w[0]), 1);
        for (int i = 0; i < 2; i++) begin
            logic [7:0] w;
            w = 8'(CAP + 2 + i);
            send(0, {1'b0, w}, {1'b1, w, 1'b0}, 1'b1, acc_x);
            if (i == 0) check("stall_release_cycle", 0, acc_x - acc1, 102);
        end
        wait_idle(0);

        // Reset in the middle of data bit 3 with words queued
        send(0, 9'h0F0, {1'b1, 8'hF0, 1'b0}, 1'b0, acc1);
        send(0, 9'h011, {1'b1, 8'h11, 1'b0}, 1'b1, acc_x);
`ifdef UART_TX_FIFO_EN
        send(0, 9'h022, {1'b1, 8'h22, 1'b0}, 1'b1, acc_x);
`endif
        k = acc1 + 1;
        while (gcycle < k + 45) @(negedge clk);
        check("pre_rst_tx", 0, int'(tx_w[0]), 0);
        check("pre_rst_level", 0, lvl(0), CAP > 1 ? 2 : 1);
        #1 reset = 1'b1;
        #1;
        check("midrst_tx", 0, int'(tx_w[0]), 1);
        check("midrst_busy", 0, int'(busy_w[0]), 0);
        check("midrst_level", 0, lvl(0), 0);
        check("midrst_done", 0, int'(done_w[0]), 0);
        check("midrst_ready", 0, int'(rdy_w[0]), 1);
        @(negedge clk);
        #1 reset = 1'b0;
        sb0.delete();
        @(negedge clk);
        repeat (150) @(negedge clk);
        check("post_rst_tx", 0, int'(tx_w[0]), 1);
        check("post_rst_level", 0, lvl(0), 0);

        // A new word after the abort transmits normally
        send(0, 9'h03C, {1'b1, 8'h3C, 1'b0}, 1'b0, acc1);
        @(negedge clk);
        check("post_rst_start", 0, int'(tx_w[0]), 0);
        wait_idle(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
